// File: rtl/log_n_pkg.sv
// Shared definitions for the power_n / log_n arithmetic pair.
package log_n_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int EXP_W = 3;
  localparam int VAL_W = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;

endpackage

// File: rtl/log_n.sv
// Sequential integer logarithm: largest k with base^k <= value, plus exact/error flags.
module log_n
  import log_n_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       base,
  input  logic [VAL_W-1:0] value,
  output logic [EXP_W-1:0] exponent,
  output logic             exact,
  output logic             error,
  output logic             done,
  output logic             busy
);

  state_t           state;
  logic [2:0]       base_r;
  logic [VAL_W-1:0] value_r;
  logic [VAL_W-1:0] acc;
  logic [EXP_W-1:0] k;
  logic [10:0]      prod;

  // Full-width product so overflow past 255 is still seen as "too big".
  assign prod = {3'b000, acc} * {8'b0000_0000, base_r};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      base_r   <= '0;
      value_r  <= '0;
      acc      <= 8'd1;
      k        <= '0;
      exponent <= '0;
      exact    <= 1'b0;
      error    <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_r  <= base;
            value_r <= value;
            acc     <= 8'd1;
            k       <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (base_r < 3'd2 || value_r == '0) begin
            exponent <= '0;
            exact    <= 1'b0;
            error    <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else if (prod > {3'b000, value_r} || k == EXP_MAX) begin
            exponent <= k;
            exact    <= (acc == value_r);
            error    <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            acc <= prod[7:0];
            k   <= k + 3'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
